// File: rtl/alu_seq_adder.sv
// Byte-serial WIDTH-bit adder/subtractor driving an external 8-bit carry-lookahead unit.
// Latency: N=WIDTH/8 RUN cycles plus one DONE cycle; START is ignored while BUSY.
module alu_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             C_OUT,
    output logic             OVERFLOW,
    output logic             ZERO,
    output logic             LA_C_IN,
    output logic [7:0]       LA_P,
    output logic [7:0]       LA_G,
    input  logic [7:0]       LA_CARRYS
);

    localparam int N    = WIDTH / 8;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [7:0] a_byte, b_byte, sum_byte;
    logic       run;

    assign run = (state_q == S_RUN);

    always_comb begin
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_byte = a_q[8*k +: 8];
                b_byte = bx_q[8*k +: 8];
            end
        end
    end

    // Lookahead drive comes only from registered state, never from START/A/B.
    assign LA_P     = run ? (a_byte ^ b_byte) : 8'h00;
    assign LA_G     = run ? (a_byte & b_byte) : 8'h00;
    assign LA_C_IN  = run ? carry_q : 1'b0;
    assign sum_byte = LA_P ^ {LA_CARRYS[6:0], LA_C_IN};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        bx_d     = bx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    a_d      = A;
                    bx_d     = SUB ? ~B : B;
                    carry_d  = C_IN;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (idx_q == IDXW'(k)) result_d[8*k +: 8] = sum_byte;
                end
                carry_d = LA_CARRYS[7];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = LA_CARRYS[7];
                    ovf_d   = LA_CARRYS[7] ^ LA_CARRYS[6];
                    zero_d  = (result_d == '0);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            bx_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            bx_q     <= bx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign BUSY     = run;
    assign DONE     = (state_q == S_DONE);
    assign RESULT   = result_q;
    assign C_OUT    = cout_q;
    assign OVERFLOW = ovf_q;
    assign ZERO     = zero_q;

endmodule

// File: tb/tb_alu_seq_adder.sv
// Bench for alu_seq_adder: behavioural lookahead unit, vector table, scoreboard on DONE.
module tb_alu_seq_adder;

    localparam int W = 32;
    localparam int N = W / 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         SUB = 1'b0;
    logic         C_IN = 1'b0;
    logic         BUSY, DONE, C_OUT, OVERFLOW, ZERO, LA_C_IN;
    logic [W-1:0] RESULT;
    logic [7:0]   LA_P, LA_G, LA_CARRYS;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[6];

    always #5 CLK = ~CLK;

    alu_seq_adder #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .SUB(SUB), .C_IN(C_IN),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .C_OUT(C_OUT), .OVERFLOW(OVERFLOW),
        .ZERO(ZERO), .LA_C_IN(LA_C_IN), .LA_P(LA_P), .LA_G(LA_G), .LA_CARRYS(LA_CARRYS)
    );

    // External ripple-equivalent lookahead unit.
    always_comb begin
        logic c;
        c = LA_C_IN;
        LA_CARRYS = 8'h00;
        for (int i = 0; i < 8; i++) begin
            LA_CARRYS[i] = LA_G[i] | (LA_P[i] & c);
            c = LA_CARRYS[i];
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        vec_t v;
        logic [W-1:0] bx;
        logic [W:0]   s;
        bx = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
        v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        v.res  = s[W-1:0];
        v.cout = s[W];
        v.ovf  = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
        v.zero = (s[W-1:0] == '0);
        return v;
    endfunction

    always @(negedge CLK) begin
        if (!BUSY) chk("la_idle", {15'd0, LA_C_IN, LA_P, LA_G}, '0);
        if (DONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("result", RESULT, e.res);
                chk("c_out", {31'd0, C_OUT}, {31'd0, e.cout});
                chk("overflow", {31'd0, OVERFLOW}, {31'd0, e.ovf});
                chk("zero", {31'd0, ZERO}, {31'd0, e.zero});
            end
        end
    end

    task automatic start_op(input vec_t v, input bit push);
        @(negedge CLK);
        START = 1'b1; A = v.a; B = v.b; SUB = v.sub; C_IN = v.cin;
        if (push) sb.push_back(v);
        @(posedge CLK);
    endtask

    // Called just after the accepting edge; returns at the DONE-cycle negedge.
    task automatic check_timing(input int pulse_at, input logic [W-1:0] alt_a,
                                input logic [W-1:0] alt_b);
        for (int c = 1; c <= N; c++) begin
            @(negedge CLK);
            chk("busy_run", {31'd0, BUSY}, 32'd1);
            chk("done_run", {31'd0, DONE}, 32'd0);
            START = (c == pulse_at);
            if (c == pulse_at) begin
                A = alt_a; B = alt_b; SUB = 1'b0; C_IN = 1'b0;
            end
        end
        @(negedge CLK);
        chk("done_pulse", {31'd0, DONE}, 32'd1);
        chk("busy_done", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h12345678, 32'h12345678, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_result", RESULT, '0);
        chk("rst_flags", {29'd0, C_OUT, OVERFLOW, ZERO}, '0);
        RST = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i], 1'b1);
            check_timing(0, '0, '0);
            @(negedge CLK);
            chk("result_hold", RESULT, vecs[i].res);
        end

        for (int i = 0; i < 6; i++) begin
            v = model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            start_op(v, 1'b1);
            check_timing(0, '0, '0);
        end

        // START during RUN is ignored.
        v = model(32'h01020304, 32'h10203040, 1'b0, 1'b0);
        start_op(v, 1'b1);
        check_timing(2, 32'hDEADBEEF, 32'h11111111);
        repeat (3) @(negedge CLK);
        chk("ignored_start_idle", {31'd0, BUSY}, 32'd0);

        // Reset in the second RUN cycle discards the operation.
        v = model(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1);
        start_op(v, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_done", {31'd0, DONE}, 32'd0);
        chk("midrst_result", RESULT, '0);
        chk("midrst_flags", {29'd0, C_OUT, OVERFLOW, ZERO}, '0);
        RST = 1'b0;
        repeat (N + 2) begin
            @(negedge CLK);
            chk("midrst_no_done", {31'd0, DONE}, 32'd0);
        end

        // Back-to-back: START held through DONE with 0x10 + 0x20.
        v = model(32'h0000FF00, 32'h00000100, 1'b0, 1'b0);
        start_op(v, 1'b1);
        check_timing(N, 32'h00000010, 32'h00000020);
        sb.push_back('{32'h10, 32'h20, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0});
        @(posedge CLK);
        check_timing(0, '0, '0);

        repeat (4) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_adder.md
# alu_seq_adder

Multi-cycle WIDTH-bit adder/subtractor that drives the 8-bit carry-lookahead interface from the operand side. It processes one byte per cycle. Each cycle it generates propagate/generate for the current byte, presents them with the running carry to an external lookahead unit, consumes the returned carries, and forms the sum byte. It sits in the ALU datapath between the operand registers and the lookahead unit, which may be combinational logic or the SRAM lookup table.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 8; N = WIDTH/8 byte steps.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; accepted only when BUSY=0.
- A  input  WIDTH  operand A; sampled on the accepting edge.
- B  input  WIDTH  operand B; sampled on the accepting edge.
- SUB  input  1  1 = use ~B instead of B; sampled on the accepting edge.
- C_IN  input  1  carry-in; sampled on the accepting edge. A−B requires SUB=1, C_IN=1.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse; results valid.
- RESULT  output  WIDTH  sum, held until the next accepted START.
- C_OUT  output  1  carry out of bit WIDTH−1.
- OVERFLOW  output  1  signed overflow.
- ZERO  output  1  RESULT == 0.
- LA_C_IN  output  1  carry into the current byte.
- LA_P  output  8  propagate for the current byte.
- LA_G  output  8  generate for the current byte.
- LA_CARRYS  input  8  carries out of bits 0..7 of the current byte; combinational function of the LA_* outputs, sampled in the same cycle.

## Operation
- States: IDLE, RUN, DONE_ST. Reset → IDLE.
- Reset values: all outputs 0, byte index 0, operand/result registers 0.
- IDLE or DONE_ST with START=1:
  - Register A, SUB ? ~B : B (call it Bx), and C_IN as the running carry.
  - Set index = 0 and go to RUN.
- DONE_ST with START=0 → IDLE.
- RUN, byte k = index:
  - LA_P = A[8k+7:8k] ^ Bx[8k+7:8k].
  - LA_G = A[8k+7:8k] & Bx[8k+7:8k].
  - LA_C_IN = running carry.
- RUN edge:
  - RESULT[8k+7:8k] ← LA_P ^ {LA_CARRYS[6:0], LA_C_IN}.
  - Running carry ← LA_CARRYS[7].
  - index ← index + 1.
- RUN, last byte (k = N−1):
  - Same updates as any RUN edge.
  - C_OUT ← LA_CARRYS[7].
  - OVERFLOW ← LA_CARRYS[7] ^ LA_CARRYS[6].
  - ZERO ← (new RESULT == 0).
  - Go to DONE_ST.
- Outside RUN: LA_P, LA_G and LA_C_IN are driven 0.
- START while in RUN is ignored. Operand inputs are don't-care outside the accepting edge.
- On an accepted START, RESULT, C_OUT, OVERFLOW and ZERO clear to 0 and then build up byte by byte.
- RST at any point, including mid-RUN, gives IDLE on the next edge with all outputs 0. The pending operation is discarded and no DONE is produced.
- RST has priority over START.
- WIDTH=8: a single RUN cycle.

## Timing
- Accepting edge E0. RUN occupies the N cycles after E0; byte k is registered at edge E(k+1).
- BUSY is high for exactly N cycles.
- DONE is high for exactly one cycle, the cycle after edge EN.
- RESULT, C_OUT, OVERFLOW and ZERO are valid from that cycle and held until the next accepted START.
- Back-to-back: START high in the DONE cycle is accepted. The next BUSY follows immediately, giving N+1 cycles per operation.
- LA_* outputs depend only on registered state, so no combinational path runs from START, A or B to LA_*.
- The only combinational path into state is LA_CARRYS → RESULT byte and carry.

## Test plan
- WIDTH=32, A=0x000000FF, B=0x00000001, SUB=0, C_IN=0 → RESULT=0x00000100, C_OUT=0, OVERFLOW=0, ZERO=0. BUSY high for 4 cycles; DONE high in the 5th cycle after E0.
- A=0xFFFFFFFF, B=0x00000001, C_IN=0 → RESULT=0x00000000, C_OUT=1, ZERO=1, OVERFLOW=0. The carry must chain across all 4 byte steps.
- A=0x7FFFFFFF, B=0x00000001 → RESULT=0x80000000, OVERFLOW=1, C_OUT=0.
- SUB=1, C_IN=1:
  - A=5, B=7 → RESULT=0xFFFFFFFE, C_OUT=0 (borrow), OVERFLOW=0.
  - A=0x80000000, B=1 → RESULT=0x7FFFFFFF, OVERFLOW=1, C_OUT=1.
- START pulsed again with different operands during RUN → ignored; first result unchanged. RST asserted in the 2nd RUN cycle → next cycle IDLE, all outputs 0, no DONE pulse.
- START held high through DONE with new operands 0x10+0x20 → accepted in the DONE cycle. Second DONE arrives exactly 5 cycles later with RESULT=0x00000030. LA_P, LA_G and LA_C_IN are 0 in every non-RUN cycle.
